param_display_reader: RTL
=========================

# param_display_reader

Read-back and display-formatting block for the anti-theft controller's time-parameter store. It is the reader side of the parameter interface written via `reprogram`/`time_param_sel`/`time_value`.

- On a user request it walks the four stored intervals through a dedicated read port.
- It captures each value and presents all four as decimal digit pairs on the eight-digit display bus.
- Otherwise it shows the live FSM state and timer count.
- It sits between the parameter store, the FSM/timer and the display driver, and drives the driver's `d1`..`d8` fields.

## Interface
Parameters:
- `RD_LAT`, 1: cycles from `rd_sel` change to a valid `rd_value`. Legal range is 1..3.
- `HOLD_S`, 5: number of `one_hz_enable` pulses that the parameter page stays up. Legal range is 1..15.

Ports:
- `clock` in 1: system clock, the single clock domain. Reset is asynchronous and active-low.
- `reset` in 1: asynchronous, active-low.
- `show` in 1: request to display the parameters. Already debounced. Level input; the block acts on its rising edge.
- `one_hz_enable` in 1: one-cycle tick from the timer.
- `estado` in 4: current FSM state code.
- `counter` in 4: current timer count, range 0..15.
- `status` in 1: status LED level.
- `rd_value` in 4: parameter value returned for `rd_sel`.
- `rd_sel` out 2: parameter index being read, 0..3. Registered.
- `busy` out 1: high while a scan is in progress.
- `d1`..`d8` out 6 each: digit fields, formatted as {enable, value[3:0], dp}. Enable=0 blanks the digit.

## Operation
- States are IDLE, SCAN and SHOW. Reset forces IDLE.
- `show` is registered once; a rise is detected as `show`=1 and `show_q`=0.
- IDLE display:
  - d1 = {1, estado, 0}.
  - d2..d6 = 0 (blank).
  - d7 = {1, tens(counter), 0}.
  - d8 = {1, units(counter), status}.
- SHOW display:
  - For param i (0..3), d(2i+1) = {1, tens(p_i), 0} and d(2i+2) = {1, units(p_i), dp}.
  - dp=1 for i=0..2, and dp=0 for i=3.
- BCD rule for v ≤ 15: tens = 1 if v ≥ 10, else 0; units = v−10 if v ≥ 10, else v.
- `d1`..`d8` are decoded combinationally from registered state, the shadow registers and the inputs.
- IDLE → SCAN on a `show` rise: idx=0, `rd_sel`=0, wait=0, `busy`=1.
- SCAN behaviour on each edge:
  - If wait == RD_LAT: shadow[idx] ← `rd_value`.
  - Then if idx == 3, go to SHOW. Otherwise idx++, `rd_sel` ← idx+1, wait=0.
  - If wait < RD_LAT: wait++.
- SCAN → SHOW: `busy`=0, `rd_sel`=0, hold ← HOLD_S.
- While in SHOW:
  - Each `one_hz_enable` decrements hold.
  - The pulse that takes hold from 1 to 0 returns the block to IDLE.
  - A `show` rise restarts SCAN, with the same entry actions as from IDLE.
- Boundary cases:
  - A `show` rise during SCAN is ignored.
  - `one_hz_enable` during SCAN or IDLE is ignored.
  - `one_hz_enable` and a `show` rise in the same cycle in SHOW: the `show` rise wins, and the block goes to SCAN.
- Reset (asynchronous, at any time, including mid-scan):
  - State IDLE, idx=0, wait=0, hold=0, `show_q`=0.
  - All shadow registers = 0.
  - `rd_sel`=0, `busy`=0.
  - Outputs show the IDLE view.

## Timing
- Each index occupies RD_LAT+1 cycles; a full scan takes 4·(RD_LAT+1) cycles. With RD_LAT=1 this is 8 cycles.
- Take edge E as the edge where the `show` rise is detected:
  - `busy` is high from E to E+4(RD_LAT+1).
  - The SHOW page is valid immediately after E+4(RD_LAT+1).
- `rd_sel` = k during the window from edge E+k(RD_LAT+1) to E+(k+1)(RD_LAT+1).
- `rd_value` is sampled at edge E+k(RD_LAT+1)+RD_LAT.
- The SHOW page lasts from HOLD_S−1 to HOLD_S seconds, depending on tick phase.
- Outputs have zero added latency relative to the registered state.

## Configuration
- `PARAM_READ_BLANK_EN`: leading-zero blanking.
- Defined: any tens digit whose value is 0 gets enable=0. This applies to d7 in IDLE and to d1/d3/d5/d7 in SHOW.
- Not defined: tens digits are always enabled and display 0.

## Test plan
- Reset with `estado`=4'h5, `counter`=9, `status`=1:
  - Required: d1={1,5,0}, d7={1,0,0}, d8={1,9,1}, `busy`=0, `rd_sel`=0.
  - Required after deassertion: this view persists while `show`=0.
- RD_LAT=1, parameter model returns {3,10,15,0}, pulse `show`:
  - Required: `busy` high for 8 cycles; `rd_sel` sequence 0,0,1,1,2,2,3,3.
  - Required page: d1..d8 values 0,3,1,0,1,5,0,0, with dp on d2/d4/d6 only.
  - With the macro defined: d1 and d7 are blanked.
- HOLD_S=3:
  - Required: the block stays in SHOW through 2 ticks and returns to IDLE on the 3rd `one_hz_enable`.
  - Required: a `show` rise during SCAN leaves the rd_sel sequence unchanged.
- In SHOW, change the model's p2 to 7 and pulse `show`:
  - Required: a fresh 8-cycle scan, after which d5/d6 read 0/7.
- Assert reset at cycle 3 of a scan:
  - Required: immediate IDLE, `busy`=0, `rd_sel`=0.
  - Required: a following `show` with the model returning all zeros displays all 0s.
- IDLE with `counter`=12:
  - Required: d7={1,1,0}, d8={1,2,status}.
  - With `counter`=5 and the macro defined: d7 enable=0. With `counter`=5 and the macro undefined: d7={1,0,0}.

Source files
------------

// File: rtl/param_display_reader_if.sv
// Read port between the display reader and the time-parameter store.
// The reader drives the index; the store returns the value RD_LAT cycles later.
interface param_display_reader_if;
    logic [1:0] rd_sel;
    logic [3:0] rd_value;

    modport master (output rd_sel, input rd_value);
    modport slave  (input rd_sel, output rd_value);
endinterface

// File: rtl/param_display_reader.sv
// Parameter read-back and eight-digit display formatter for the anti-theft controller.
// Optional feature: define PARAM_READ_BLANK_EN to blank tens digits that are zero.
//
// state | meaning
// IDLE  | live view: FSM state, timer count, status LED
// SCAN  | walking the four stored intervals through the read port
// SHOW  | parameter page, held for HOLD_S one-second ticks
module param_display_reader #(
    parameter int RD_LAT = 1,
    parameter int HOLD_S = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          show,
    input  logic                          one_hz_enable,
    input  logic [3:0]                    estado,
    input  logic [3:0]                    counter,
    input  logic                          status,
    param_display_reader_if.master        rd_port,
    output logic                          busy,
    output logic [5:0]                    d1,
    output logic [5:0]                    d2,
    output logic [5:0]                    d3,
    output logic [5:0]                    d4,
    output logic [5:0]                    d5,
    output logic [5:0]                    d6,
    output logic [5:0]                    d7,
    output logic [5:0]                    d8
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [1:0] LAT  = 2'(RD_LAT);
    localparam logic [3:0] HOLD = 4'(HOLD_S);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] wait_q, wait_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] rd_sel_q, rd_sel_d;
    logic       busy_q, busy_d;
    logic       show_q;
    logic [3:0] shadow_q [4];
    logic [3:0] shadow_d [4];
    logic       show_rise;
    logic [5:0] dig [8];

    assign show_rise      = show & ~show_q;
    assign rd_port.rd_sel = rd_sel_q;
    assign busy           = busy_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            wait_q   <= 2'd0;
            hold_q   <= 4'd0;
            rd_sel_q <= 2'd0;
            busy_q   <= 1'b0;
            show_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            hold_q   <= hold_d;
            rd_sel_q <= rd_sel_d;
            busy_q   <= busy_d;
            show_q   <= show;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        hold_d   = hold_q;
        rd_sel_d = rd_sel_q;
        busy_d   = busy_q;
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
        end

        case (state_q)
            IDLE: begin
                if (show_rise) begin
                    state_d  = SCAN;
                    idx_d    = 2'd0;
                    rd_sel_d = 2'd0;
                    wait_d   = 2'd0;
                    busy_d   = 1'b1;
                end
            end
            SCAN: begin
                // show rises and ticks are deliberately ignored until the scan completes
                if (wait_q == LAT) begin
                    shadow_d[idx_q] = rd_port.rd_value;
                    if (idx_q == 2'd3) begin
                        state_d  = SHOW;
                        busy_d   = 1'b0;
                        rd_sel_d = 2'd0;
                        hold_d   = HOLD;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        rd_sel_d = idx_q + 2'd1;
                        wait_d   = 2'd0;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            SHOW: begin
                if (show_rise) begin
                    state_d  = SCAN;
                    idx_d    = 2'd0;
                    rd_sel_d = 2'd0;
                    wait_d   = 2'd0;
                    busy_d   = 1'b1;
                end else if (one_hz_enable) begin
                    if (hold_q <= 4'd1) begin
                        state_d = IDLE;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    function automatic logic [5:0] tens_digit(input logic [3:0] v);
        logic t;
        logic en;
        t  = (v >= 4'd10);
        en = 1'b1;
`ifdef PARAM_READ_BLANK_EN
        en = t;
`endif
        return {en, 3'b000, t, 1'b0};
    endfunction

    function automatic logic [5:0] units_digit(input logic [3:0] v, input logic dp);
        logic [3:0] u;
        u = (v >= 4'd10) ? (v - 4'd10) : v;
        return {1'b1, u, dp};
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dig[i] = 6'd0;
        end
        if (state_q == SHOW) begin
            // last parameter drops its decimal point to mark the end of the page
            for (int i = 0; i < 4; i++) begin
                dig[2*i]   = tens_digit(shadow_q[i]);
                dig[2*i+1] = units_digit(shadow_q[i], (i < 3));
            end
        end else begin
            dig[0] = {1'b1, estado, 1'b0};
            dig[6] = tens_digit(counter);
            dig[7] = units_digit(counter, status);
        end
    end

    assign d1 = dig[0];
    assign d2 = dig[1];
    assign d3 = dig[2];
    assign d4 = dig[3];
    assign d5 = dig[4];
    assign d6 = dig[5];
    assign d7 = dig[6];
    assign d8 = dig[7];

endmodule
